mem_responder: RTL and testbench

Word-addressed synchronous memory that answers the datapath's MAR/MDR memory requests with a level-request / one-cycle-ready handshake and a programmable number of wait states. It replaces the zero-latency memory model, so the control unit can stall in a memory step until `mem_ready` pulses. It connects as follows:
- Request side: `read`/`write` from the control unit, `mar` from MAR, `mdr_in` from MDR.
- Response side: `mdatain` feeds the MDR input mux.

---
 rtl/mem_responder_if.sv | 34 +++
 rtl/mem_responder.sv | 157 +++++++++++++++
 tb/tb_mem_responder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between the control unit's MAR/MDR datapath and mem_responder.
// The initiator drives level requests; the memory answers with a one-cycle ready pulse.
interface mem_responder_if;
  logic        read;
  logic        write;
  logic [31:0] mar;
  logic [31:0] mdr_in;
  logic [31:0] mdatain;
  logic        mem_ready;
  logic        mem_busy;
  logic        mem_err;

  modport master (
    output read,
    output write,
    output mar,
    output mdr_in,
    input  mdatain,
    input  mem_ready,
    input  mem_busy,
    input  mem_err
  );

  modport slave (
    input  read,
    input  write,
    input  mar,
    input  mdr_in,
    output mdatain,
    output mem_ready,
    output mem_busy,
    output mem_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory with programmable wait states and a level-request / ready-pulse handshake.
// Optional address range check and read/write collision flag: define MEM_RESP_RANGE_CHK_EN.
module mem_responder #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic           clk_i,
  input  logic           clr_ni,
  mem_responder_if.slave bus
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam logic [3:0]  CntInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp, StHold} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                wr_q, wr_d;
  logic [31:0]         mdatain_q, mdatain_d;
  logic                err_q, err_d;
  logic [31:0]         mem_q [Depth];

  logic req;
  logic accept;
  logic acc_go;
  logic acc_bad;

  assign req    = bus.read | bus.write;
  assign accept = (state_q == StIdle) & req;

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = (WAIT_STATES == 0) ? StResp : StWait;
          cnt_d   = CntInit;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StResp;
        end
      end
      StResp: state_d = StHold;
      StHold: begin
        if (!req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.mem_ready = (state_q == StResp);
    bus.mem_busy  = (state_q != StIdle);
    bus.mem_err   = err_q & (state_q == StResp);
    bus.mdatain   = mdatain_q;
  end

  // The _d copies show the live request on acceptance and the latched one afterwards, so the
  // access below works unchanged whether RESP is entered from IDLE or from WAIT.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    wr_d   = wr_q;
    if (accept) begin
      addr_d = bus.mar[ADDR_W-1:0];
      data_d = bus.mdr_in;
      wr_d   = bus.write;
    end
  end

  // Gated by clr_ni so a zero-wait request held during reset cannot reach the array.
  assign acc_go = clr_ni & (state_d == StResp) & (state_q != StResp);

`ifdef MEM_RESP_RANGE_CHK_EN
  logic hi_q, hi_d;
  logic both_q, both_d;

  always_comb begin
    hi_d   = hi_q;
    both_d = both_q;
    if (accept) begin
      hi_d   = |bus.mar[31:ADDR_W];
      both_d = bus.read & bus.write;
    end
  end

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      hi_q   <= 1'b0;
      both_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      both_q <= both_d;
    end
  end

  assign acc_bad = hi_d;
  assign err_d   = acc_go & (hi_d | both_d);
`else
  logic unused_mar_hi;

  assign unused_mar_hi = ^bus.mar[31:ADDR_W];
  assign acc_bad       = 1'b0;
  assign err_d         = 1'b0;
`endif

  always_comb begin
    mdatain_d = mdatain_q;
    if (acc_go && !wr_d) begin
      mdatain_d = acc_bad ? 32'h0 : mem_q[addr_d];
    end
  end

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      mdatain_q <= '0;
      err_q     <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      mdatain_q <= mdatain_d;
      err_q     <= err_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (acc_go && wr_d && !acc_bad) begin
      mem_q[addr_d] <= data_d;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with two wait states, one with none.
module tb_mem_responder;
  localparam int unsigned AddrW = 9;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;

  logic        sel;
  logic        t_rd;
  logic        t_wr;
  logic [31:0] t_mar;
  logic [31:0] t_mdr;

  mem_responder_if if0 ();
  mem_responder_if if1 ();

  assign if0.read   = t_rd & ~sel;
  assign if0.write  = t_wr & ~sel;
  assign if0.mar    = t_mar;
  assign if0.mdr_in = t_mdr;
  assign if1.read   = t_rd & sel;
  assign if1.write  = t_wr & sel;
  assign if1.mar    = t_mar;
  assign if1.mdr_in = t_mdr;

  mem_responder #(.ADDR_W(AddrW), .WAIT_STATES(2)) u_dut0 (
    .clk_i  (clk),
    .clr_ni (clr_n),
    .bus    (if0)
  );

  mem_responder #(.ADDR_W(AddrW), .WAIT_STATES(0)) u_dut1 (
    .clk_i  (clk),
    .clr_ni (clr_n),
    .bus    (if1)
  );

  logic        cur_ready;
  logic        cur_busy;
  logic        cur_err;
  logic [31:0] cur_mdatain;

  assign cur_ready   = sel ? if1.mem_ready : if0.mem_ready;
  assign cur_busy    = sel ? if1.mem_busy  : if0.mem_busy;
  assign cur_err     = sel ? if1.mem_err   : if0.mem_err;
  assign cur_mdatain = sel ? if1.mdatain   : if0.mdatain;

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } sb_t;

  sb_t         sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          chk_en;
  logic [31:0] model_mem [2][512];
  logic [31:0] last_rd [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    sb_t e;
    if (cur_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("mdatain", cur_mdatain, e.data);
        check("mem_err", {31'b0, cur_err}, {31'b0, e.err});
      end
    end
  end

  task automatic do_req(input int s, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input int hold);
    sb_t            e;
    int             n;
    bit             got;
    bit             bad;
    logic [AddrW-1:0] idx;
    idx   = addr[AddrW-1:0];
    bad   = chk_en && ((addr >> AddrW) != 32'd0);
    e.err = chk_en && (bad || (rd && wr));
    if (wr) begin
      if (!bad) model_mem[s][idx] = data;
      e.data = last_rd[s];
    end else begin
      e.data = bad ? 32'h0 : model_mem[s][idx];
      last_rd[s] = e.data;
    end
    sb_q.push_back(e);
    sel   = (s != 0);
    t_rd  = rd;
    t_wr  = wr;
    t_mar = addr;
    t_mdr = data;
    @(negedge clk);
    n = 1;
    check("busy_after_accept", {31'b0, cur_busy}, 32'd1);
    t_mar = ~addr;
    t_mdr = ~data;
    got   = cur_ready;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = cur_ready;
    end
    check("ready_latency", 32'(n), (s != 0) ? 32'd1 : 32'd3);
    if (!got) void'(sb_q.pop_back());
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("busy_hold", {31'b0, cur_busy}, 32'd1);
    end
    t_rd = 1'b0;
    t_wr = 1'b0;
    @(negedge clk);
    check("busy_drop", {31'b0, cur_busy}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mdatain"}, cur_mdatain, 32'h0);
    check({tag, "_ready"}, {31'b0, cur_ready}, 32'd0);
    check({tag, "_busy"}, {31'b0, cur_busy}, 32'd0);
    check({tag, "_err"}, {31'b0, cur_err}, 32'd0);
  endtask

  task automatic reset_mid_wait();
    sel   = 1'b0;
    t_rd  = 1'b0;
    t_wr  = 1'b1;
    t_mar = 32'h20;
    t_mdr = 32'hFFFF_0000;
    @(negedge clk);
    check("busy_in_wait", {31'b0, cur_busy}, 32'd1);
    #2 clr_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    t_wr = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    chk_en = 1'b0;
`ifdef MEM_RESP_RANGE_CHK_EN
    chk_en = 1'b1;
`endif
    sel        = 1'b0;
    t_rd       = 1'b0;
    t_wr       = 1'b0;
    t_mar      = 32'h0;
    t_mdr      = 32'h0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    clr_n      = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("rst0");
    sel = 1'b1;
    #1;
    check_idle_outputs("rst1");
    sel   = 1'b0;
    clr_n = 1'b1;
    @(negedge clk);

    do_req(0, 1'b0, 1'b1, 32'h10, 32'h1234_5678, 1);
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1);
    do_req(1, 1'b0, 1'b1, 32'h3, 32'hA5A5_0001, 1);
    do_req(1, 1'b1, 1'b0, 32'h3, 32'h0, 1);
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 6);
    do_req(0, 1'b0, 1'b1, 32'h20, 32'h0000_0001, 1);
    reset_mid_wait();
    do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 1);
    do_req(0, 1'b1, 1'b1, 32'h40, 32'h0000_0055, 1);
    do_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 1);
    do_req(0, 1'b0, 1'b1, 32'h0000_0210, 32'hDEAD_BEEF, 1);
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1);
    do_req(0, 1'b1, 1'b0, 32'h0000_0210, 32'h0, 1);

    for (int i = 0; i < 6; i++) begin
      a = 32'($urandom_range(0, 511));
      d = $urandom;
      do_req(i % 2, 1'b0, 1'b1, a, d, 1);
      do_req(i % 2, 1'b1, 1'b0, a, 32'h0, 1 + (i % 3));
    end

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
